// File: rtl/ds1302_pkg.sv
// Shared DS1302 serial-write definitions: FSM encodings, frame timing and the
// write-protect frame. WP_WRITE/GAP exist only with DS1302_WR_WP_CLEAR_EN.
package ds1302_pkg;

    localparam int CE_SETUP = 5;
    localparam int BIT_NUM  = 16;
    localparam int CE_HOLD  = 3;
    localparam int CE_GAP   = 4;

    localparam logic [7:0] WP_ADDR = 8'h8E;
    localparam logic [7:0] WP_CLR  = 8'h00;

    localparam int CNT_W = 7;

    // Counter values inside a frame state; the counter is 0 in the first ce-high cycle.
    localparam logic [CNT_W-1:0] BIT_FIRST  = CNT_W'(CE_SETUP - 1);
    localparam logic [CNT_W-1:0] SCLK_FIRST = CNT_W'(CE_SETUP);
    localparam logic [CNT_W-1:0] SCLK_LAST  = CNT_W'(CE_SETUP + 2*(BIT_NUM-1));
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CE_SETUP + 2*(BIT_NUM-2));
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(CE_SETUP + 2*(BIT_NUM-1) + 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(CE_SETUP + 2*(BIT_NUM-1) + CE_HOLD);
    // ce stays low through the whole gap (>= tCWH); its length also places the
    // user frame exactly 45 cycles after the write-protect frame.
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CE_GAP + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1
`ifdef DS1302_WR_WP_CLEAR_EN
        ,
        WP_WRITE = 2'd2,
        GAP      = 2'd3
`endif
    } state_t;

    // Wire order is LSB first: command byte, then data; bit 0 forced to write.
    function automatic logic [15:0] wr_frame(input logic [7:0] cmd, input logic [7:0] dat);
        return {dat, cmd[7:1], 1'b0};
    endfunction

endpackage

// File: rtl/signle_pluse.sv
// Rising-edge detector producing a one-cycle pulse, one cycle after the edge.
module signle_pluse (
    input  logic clk,
    input  logic rst_n,
    input  logic in_sig,
    output logic pulse
);

    logic d_q;
    logic d2_q;

    // Reset to the idle level of the input so leaving reset never fires a pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= 1'b1;
            d2_q <= 1'b1;
        end else begin
            d_q  <= in_sig;
            d2_q <= d_q;
        end
    end

    assign pulse = d_q & ~d2_q;

endmodule

// File: rtl/spi_wr.sv
// DS1302 single-register write master: one 16-bit LSB-first frame per start.
// Define DS1302_WR_WP_CLEAR_EN to precede every write with a WP-clear frame.
module spi_wr
    import ds1302_pkg::*;
(
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       wr_start_flag,
    input  logic [7:0] control_data,
    input  logic [7:0] wr_reg_data,
    output logic       sclk,
    output logic       wr_data,
    output logic       ce,
    output logic       inout_en,
    output logic       busy,
    output logic       wr_done
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        shift_q, shift_d;
    logic               txn_q;
    logic               in_frame;
    logic               txn;

`ifdef DS1302_WR_WP_CLEAR_EN
    logic [7:0]         ctrl_q, ctrl_d;
    logic [7:0]         data_q, data_d;
    assign in_frame = (state_q == WRITE) || (state_q == WP_WRITE);
`else
    assign in_frame = (state_q == WRITE);
`endif
    assign txn = (state_q != IDLE);

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            txn_q   <= 1'b0;
`ifdef DS1302_WR_WP_CLEAR_EN
            ctrl_q  <= '0;
            data_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            txn_q   <= txn;
`ifdef DS1302_WR_WP_CLEAR_EN
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        shift_d = shift_q;
`ifdef DS1302_WR_WP_CLEAR_EN
        ctrl_d  = ctrl_q;
        data_d  = data_q;
`endif
        // Advance to the next bit right after each sclk-high cycle, except the last.
        if (in_frame && cnt_q[0] && cnt_q >= SCLK_FIRST && cnt_q <= SHIFT_LAST)
            shift_d = {1'b0, shift_q[15:1]};

        case (state_q)
            IDLE: begin
                if (wr_start_flag) begin
`ifdef DS1302_WR_WP_CLEAR_EN
                    ctrl_d  = control_data;
                    data_d  = wr_reg_data;
                    shift_d = wr_frame(WP_ADDR, WP_CLR);
                    state_d = WP_WRITE;
`else
                    shift_d = wr_frame(control_data, wr_reg_data);
                    state_d = WRITE;
`endif
                end
            end
            WRITE: begin
                if (cnt_q == FRAME_LAST) state_d = IDLE;
            end
`ifdef DS1302_WR_WP_CLEAR_EN
            WP_WRITE: begin
                if (cnt_q == FRAME_LAST) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    shift_d = wr_frame(ctrl_q, data_q);
                    state_d = WRITE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (state_q == IDLE || state_d != state_q) cnt_d = '0;
    end

    // Outputs decode straight from registers so an async reset clears them at once.
    assign ce       = in_frame;
    assign inout_en = ce;
    assign sclk     = in_frame && cnt_q[0] && cnt_q >= SCLK_FIRST && cnt_q <= SCLK_LAST;
    assign wr_data  = in_frame && cnt_q >= BIT_FIRST && cnt_q <= DATA_LAST && shift_q[0];

`ifdef DS1302_WR_WP_CLEAR_EN
    // ce drops during GAP, so completion keys off the whole transaction instead.
    signle_pluse u_done (.clk(sys_clk), .rst_n(rst), .in_sig(~txn), .pulse(wr_done));
`else
    signle_pluse u_done (.clk(sys_clk), .rst_n(rst), .in_sig(~ce), .pulse(wr_done));
`endif

    assign busy = txn | txn_q | wr_done;

endmodule

// File: tb/tb_spi_wr.sv
// Directed bench for spi_wr: a vector table of single writes plus ignored-start,
// back-to-back and mid-frame reset sequences.
module tb_spi_wr;

`ifdef DS1302_WR_WP_CLEAR_EN
    localparam int OFS = 45;
    localparam int NP  = 32;
`else
    localparam int OFS = 0;
    localparam int NP  = 16;
`endif

    logic       sys_clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_start_flag = 1'b0;
    logic [7:0] control_data = 8'h00;
    logic [7:0] wr_reg_data = 8'h00;
    logic       sclk, wr_data, ce, inout_en, busy, wr_done;

    spi_wr dut (
        .sys_clk(sys_clk), .rst(rst), .wr_start_flag(wr_start_flag),
        .control_data(control_data), .wr_reg_data(wr_reg_data),
        .sclk(sclk), .wr_data(wr_data), .ce(ce), .inout_en(inout_en),
        .busy(busy), .wr_done(wr_done)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic ce_a[0:199], sclk_a[0:199], wd_a[0:199], ie_a[0:199], busy_a[0:199], done_a[0:199];
    logic pre_sclk;

    int          a_pulses, a_fce, a_lce, a_dk, a_dn, a_fb, a_lb, a_mis, a_ie, a_bz;
    logic [31:0] a_bits;

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  d;
        logic [15:0] frame;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Start at C0, optionally pulse start again at cycles s1/s2 (with bytes c2/d2)
    // and pull reset at cycle rk; record outputs mid-cycle for C1..Cn.
    task automatic run(input logic [7:0] c, input logic [7:0] d, input int s1, input int s2,
                       input logic [7:0] c2, input logic [7:0] d2, input int rk, input int n);
        ce_a[0] = 0; sclk_a[0] = 0; wd_a[0] = 0; ie_a[0] = 0; busy_a[0] = 0; done_a[0] = 0;
        @(negedge sys_clk);
        wr_start_flag = 1'b1; control_data = c; wr_reg_data = d;
        for (int k = 1; k <= n; k++) begin
            @(posedge sys_clk); #1;
            wr_start_flag = (k == s1) || (k == s2);
            if (wr_start_flag) begin control_data = c2; wr_reg_data = d2; end
            if (k == rk + 2) rst = 1'b1;
            if (k == rk) begin
                #2 pre_sclk = sclk;
                rst = 1'b0;
            end
            @(negedge sys_clk);
            ce_a[k] = ce; sclk_a[k] = sclk; wd_a[k] = wr_data;
            ie_a[k] = inout_en; busy_a[k] = busy; done_a[k] = wr_done;
        end
        wr_start_flag = 1'b0;
    endtask

    // Scan C(b+1)..C(hi); pulse p of a transaction started at C(b) belongs at b+6+2p.
    task automatic analyze(input int b, input int hi);
        a_pulses = 0; a_bits = '0; a_fce = -1; a_lce = -1; a_dk = -1; a_dn = 0;
        a_fb = -1; a_lb = -1; a_mis = 0; a_ie = 0; a_bz = 0;
        for (int k = b + 1; k <= hi; k++) begin
            if (sclk_a[k] && !sclk_a[k-1]) begin
                if (a_pulses < 32) a_bits[a_pulses] = wd_a[k];
                if (k != b + 6 + 2*(a_pulses % 16) + ((a_pulses >= 16) ? OFS : 0)) a_mis++;
                a_pulses++;
            end
            if (ce_a[k]) begin if (a_fce < 0) a_fce = k; a_lce = k; end
            if (done_a[k]) begin if (a_dk < 0) a_dk = k; a_dn++; end
            if (busy_a[k]) begin if (a_fb < 0) a_fb = k; a_lb = k; end
            if (ie_a[k] !== ce_a[k]) a_ie++;
        end
        for (int k = b + 1; k <= a_lb; k++) if (!busy_a[k]) a_bz++;
    endtask

    function automatic logic [15:0] user_frame(input logic [31:0] bits);
        return (OFS > 0) ? bits[31:16] : bits[15:0];
    endfunction

    initial begin
        vecs[0] = '{8'h80, 8'h25, 16'h2580};
        vecs[1] = '{8'h81, 8'h25, 16'h2580};
        vecs[2] = '{8'hFF, 8'hFF, 16'hFFFE};
        vecs[3] = '{8'h00, 8'h00, 16'h0000};
        vecs[4] = '{8'h84, 8'h12, 16'h1284};
        vecs[5] = '{8'h55, 8'hAA, 16'hAA54};

        // Reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_ce", ce, 0);        chk("rst_sclk", sclk, 0);
        chk("rst_wr_data", wr_data, 0); chk("rst_inout_en", inout_en, 0);
        chk("rst_busy", busy, 0);    chk("rst_wr_done", wr_done, 0);
        rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        chk("idle_busy", busy, 0);   chk("idle_wr_done", wr_done, 0);

        for (int v = 0; v < 6; v++) begin
            run(vecs[v].c, vecs[v].d, -1, -1, 8'h00, 8'h00, -1, 48 + OFS);
            analyze(0, 48 + OFS);
            chk($sformatf("v%0d_frame", v), user_frame(a_bits), vecs[v].frame);
            chk($sformatf("v%0d_first_bit", v), a_bits[0], 0);
            if (OFS > 0) chk($sformatf("v%0d_wp_frame", v), a_bits[15:0], 16'h008E);
            chk($sformatf("v%0d_pulses", v), a_pulses, NP);
            chk($sformatf("v%0d_pulse_pos", v), a_mis, 0);
            chk($sformatf("v%0d_ce_rise", v), a_fce, 1);
            chk($sformatf("v%0d_ce_last", v), a_lce, 39 + OFS);
            chk($sformatf("v%0d_done_cyc", v), a_dk, 41 + OFS);
            chk($sformatf("v%0d_done_cnt", v), a_dn, 1);
            chk($sformatf("v%0d_busy_first", v), a_fb, 1);
            chk($sformatf("v%0d_busy_last", v), a_lb, 41 + OFS);
            chk($sformatf("v%0d_busy_holes", v), a_bz, 0);
            chk($sformatf("v%0d_inout_en", v), a_ie, 0);
            chk($sformatf("v%0d_tail_data", v),
                {wd_a[38+OFS], wd_a[39+OFS], wd_a[40+OFS], wd_a[4], wd_a[1]}, 0);
        end

        // Starts during the transaction are dropped
        run(8'h3C, 8'hC3, 10, 30, 8'hFF, 8'hFF, -1, 60 + OFS);
        analyze(0, 60 + OFS);
        chk("ign_frame", user_frame(a_bits), 16'hC33C);
        chk("ign_pulses", a_pulses, NP);
        chk("ign_done_cnt", a_dn, 1);
        chk("ign_done_cyc", a_dk, 41 + OFS);

        // Start in the wr_done cycle runs a second frame back to back
        run(8'h80, 8'h25, 41 + OFS, -1, 8'h55, 8'hAA, -1, 2*(41 + OFS) + 5);
        analyze(0, 41 + OFS);
        chk("b2b_frame1", user_frame(a_bits), 16'h2580);
        chk("b2b_done1", a_dk, 41 + OFS);
        chk("b2b_ce_gap", {ce_a[40+OFS], ce_a[41+OFS]}, 0);
        analyze(41 + OFS, 2*(41 + OFS) + 5);
        chk("b2b_ce_rise2", a_fce, 42 + OFS);
        chk("b2b_frame2", user_frame(a_bits), 16'hAA54);
        chk("b2b_pulses2", a_pulses, NP);
        chk("b2b_pulse_pos2", a_mis, 0);
        chk("b2b_done2", a_dk, 2*(41 + OFS));
        chk("b2b_done_cnt2", a_dn, 1);

        // Reset at C20 (an sclk-high cycle) abandons the frame
        run(8'h80, 8'h25, -1, -1, 8'h00, 8'h00, 20, 70);
        chk("mrst_sclk_before", pre_sclk, 1);
        chk("mrst_ce", ce_a[20], 0);
        chk("mrst_sclk", sclk_a[20], 0);
        chk("mrst_wr_data", wd_a[20], 0);
        chk("mrst_busy", busy_a[20], 0);
        analyze(20, 70);
        chk("mrst_no_done", a_dn, 0);
        chk("mrst_no_busy", a_fb, -1);
        chk("mrst_no_ce", a_fce, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
